gate_sweep_checker: RTL

Parametrised, synthesizable successor to the gate test benches: sweeps all 2^WIDTH input vectors into a gate under test, waits a configurable DUT latency, then compares the DUT output against the expected value for a runtime-selected gate function. It counts mismatches and reports pass/fail. It sits beside any combinational gate, or a registered gate such as a D flop, inside a bench or on-chip self-test wrapper.

---
 rtl/gate_sweep_pkg.sv | 55 +++++
 rtl/gate_sweep_ref.sv | 20 ++
 rtl/gate_sweep_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared encodings and the reference gate function for the gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    MODE_NOT  = 3'd0,
    MODE_AND  = 3'd1,
    MODE_NAND = 3'd2,
    MODE_OR   = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XOR  = 3'd5,
    MODE_XNOR = 3'd6,
    MODE_BUF  = 3'd7
  } gate_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int MAX_WIDTH = 8;

  // Reductions only consider the low 'width' bits of vec.
  function automatic logic expected_out(input logic [2:0] mode,
                                        input logic [MAX_WIDTH-1:0] vec,
                                        input int width);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic r;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        r_and = r_and & vec[i];
        r_or  = r_or | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (mode)
      MODE_NOT:  r = ~vec[0];
      MODE_AND:  r = r_and;
      MODE_NAND: r = ~r_and;
      MODE_OR:   r = r_or;
      MODE_NOR:  r = ~r_or;
      MODE_XOR:  r = r_xor;
      MODE_XNOR: r = ~r_xor;
      default:   r = vec[0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational expected-value model: gate mode and stimulus in, expected bit out.
module gate_sweep_ref
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] vec,
  output logic             expected
);

  logic [MAX_WIDTH-1:0] vec_pad;

  always_comb begin
    vec_pad             = '0;
    vec_pad[WIDTH-1:0]  = vec;
    expected            = expected_out(mode, vec_pad, WIDTH);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweep of a gate under test with mismatch counting and pass/fail.
// Optional first-failing-vector capture is enabled by defining GATE_SWEEP_FAIL_VEC_EN.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 0,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       gate_mode,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef GATE_SWEEP_FAIL_VEC_EN
  output logic [WIDTH-1:0] fail_vec,
`endif
  output state_e           dbg_state
);

  localparam logic [2:0] WAIT_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [2:0]       wait_q, wait_d;
  logic             exp_bit;
  logic             mismatch;
`ifdef GATE_SWEEP_FAIL_VEC_EN
  logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
  logic             fail_seen_q, fail_seen_d;
`endif

  gate_sweep_ref #(.WIDTH(WIDTH)) u_ref (
    .mode     (mode_q),
    .vec      (stim_q),
    .expected (exp_bit)
  );

  assign mismatch = (state_q == ST_CHECK) && (dut_out != exp_bit);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stim_d  = stim_q;
    err_d   = err_q;
    pass_d  = pass_q;
    wait_d  = wait_q;
`ifdef GATE_SWEEP_FAIL_VEC_EN
    fail_vec_d  = fail_vec_q;
    fail_seen_d = fail_seen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = gate_mode;
          stim_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          wait_d  = 3'd0;
          state_d = (LATENCY == 0) ? ST_CHECK : ST_SETTLE;
`ifdef GATE_SWEEP_FAIL_VEC_EN
          fail_vec_d  = '0;
          fail_seen_d = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 3'd0;
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
`ifdef GATE_SWEEP_FAIL_VEC_EN
        if (mismatch && !fail_seen_q) begin
          fail_vec_d  = stim_q;
          fail_seen_d = 1'b1;
        end
`endif
        // pass uses err_d so a mismatch on the final vector is included.
        if (stim_q == {WIDTH{1'b1}}) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = (LATENCY == 0) ? ST_CHECK : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      stim_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      wait_q  <= 3'd0;
`ifdef GATE_SWEEP_FAIL_VEC_EN
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
`ifdef GATE_SWEEP_FAIL_VEC_EN
      fail_vec_q  <= fail_vec_d;
      fail_seen_q <= fail_seen_d;
`endif
    end
  end

  assign stim      = stim_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign dbg_state = state_q;
`ifdef GATE_SWEEP_FAIL_VEC_EN
  assign fail_vec  = fail_vec_q;
`endif

endmodule
